// File: rtl/regfile_pkg.sv
// Shared types and helpers for the register-file operand fetch block.
package regfile_pkg;

  localparam int NREG = 32;
  localparam int AW   = $clog2(NREG);
  localparam int DW   = 32;

  typedef logic [AW-1:0] reg_addr_t;
  typedef logic [DW-1:0] reg_data_t;

  localparam reg_addr_t ZERO_REG = '0;

  // Operand source priority: x0 is hardwired zero, then same-cycle writeback, then the file.
  function automatic reg_data_t sel_operand(
    input reg_addr_t rs,
    input logic      wb_valid,
    input reg_addr_t wb_rd,
    input reg_data_t wb_data,
    input reg_data_t rf_rd
  );
    if (rs == ZERO_REG)                  return '0;
    else if (wb_valid && (wb_rd == rs))  return wb_data;
    else                                 return rf_rd;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-destination scoreboard: busy vector, effective-busy lookups and sticky writeback error.
module regfile_scoreboard
  import regfile_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            wb_valid_i,
  input  reg_addr_t       wb_rd_i,
  input  logic            set_en_i,
  input  reg_addr_t       set_rd_i,
  input  reg_addr_t       rs1_i,
  input  reg_addr_t       rs2_i,
  input  reg_addr_t       rd_i,
  output logic            eb_rs1_o,
  output logic            eb_rs2_o,
  output logic            eb_rd_o,
  output logic [NREG-1:0] busy_o,
  output logic            wb_err_o
);

  logic [NREG-1:0] busy_q, busy_d;
  logic [NREG-1:0] wb_clr;
  logic [NREG-1:0] eb;
  logic            wb_err_q, wb_err_d;

  // Effective busy: a register being written back this cycle no longer blocks issue.
  always_comb begin
    wb_clr = '0;
    if (wb_valid_i) wb_clr[wb_rd_i] = 1'b1;
    eb       = busy_q & ~wb_clr;
    eb_rs1_o = eb[rs1_i];
    eb_rs2_o = eb[rs2_i];
    eb_rd_o  = eb[rd_i];
  end

  // Next state: clear on writeback first, then a new destination set overrides it.
  always_comb begin
    busy_d = busy_q & ~wb_clr;
    if (set_en_i && (set_rd_i != ZERO_REG)) busy_d[set_rd_i] = 1'b1;
    busy_d[0] = 1'b0;
    wb_err_d  = wb_err_q |
                (wb_valid_i && (wb_rd_i != ZERO_REG) && !busy_q[wb_rd_i]);
  end

  // State register; reset drops every pending entry and the error flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q   <= '0;
      wb_err_q <= 1'b0;
    end else begin
      busy_q   <= busy_d;
      wb_err_q <= wb_err_d;
    end
  end

  assign busy_o   = busy_q;
  assign wb_err_o = wb_err_q;

endmodule

// File: rtl/regfile_operand_fetch.sv
// Operand fetch: hazard-checked issue, writeback bypass and a registered operand bundle.
module regfile_operand_fetch
  import regfile_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            iss_valid,
  output logic            iss_ready,
  input  reg_addr_t       iss_rs1,
  input  reg_addr_t       iss_rs2,
  input  reg_addr_t       iss_rd,
  input  logic            iss_rd_en,
  input  logic            wb_valid,
  input  reg_addr_t       wb_rd,
  input  reg_data_t       wb_data,
  output logic            op_valid,
  input  logic            op_ready,
  output reg_data_t       op_a,
  output reg_data_t       op_b,
  output reg_addr_t       op_rd,
  output logic            op_rd_en,
  output reg_addr_t       rf_a1,
  output reg_addr_t       rf_a2,
  input  reg_data_t       rf_rd1,
  input  reg_data_t       rf_rd2,
  output reg_addr_t       rf_a3,
  output reg_data_t       rf_wd3,
  output logic            rf_we3,
  output logic [NREG-1:0] busy_mask,
  output logic            wb_err
);

  logic      eb_rs1, eb_rs2, eb_rd;
  logic      hazard, slot_free, accept;
  logic      op_valid_q, op_valid_d;
  reg_data_t op_a_q, op_a_d, op_b_q, op_b_d;
  reg_addr_t op_rd_q, op_rd_d;
  logic      op_rd_en_q, op_rd_en_d;

  // Register file ports are pure pass-throughs; x0 writes are suppressed.
  assign rf_a1  = iss_rs1;
  assign rf_a2  = iss_rs2;
  assign rf_a3  = wb_rd;
  assign rf_wd3 = wb_data;
  assign rf_we3 = wb_valid && (wb_rd != ZERO_REG);

  regfile_scoreboard u_sb (
    .clk        (clk),
    .rst        (rst),
    .wb_valid_i (wb_valid),
    .wb_rd_i    (wb_rd),
    .set_en_i   (accept && iss_rd_en),
    .set_rd_i   (iss_rd),
    .rs1_i      (iss_rs1),
    .rs2_i      (iss_rs2),
    .rd_i       (iss_rd),
    .eb_rs1_o   (eb_rs1),
    .eb_rs2_o   (eb_rs2),
    .eb_rd_o    (eb_rd),
    .busy_o     (busy_mask),
    .wb_err_o   (wb_err)
  );

  // Handshake: ready is independent of iss_valid so decode can rely on it combinationally.
  always_comb begin
    hazard    = eb_rs1 || eb_rs2 || (iss_rd_en && eb_rd);
    slot_free = !op_valid_q || op_ready;
    iss_ready = slot_free && !hazard;
    accept    = iss_valid && iss_ready;
  end

  // Output bundle next state: load on accept, hold while stalled, empty on consume.
  always_comb begin
    op_valid_d = op_valid_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    op_rd_d    = op_rd_q;
    op_rd_en_d = op_rd_en_q;
    if (accept) begin
      op_valid_d = 1'b1;
      op_a_d     = sel_operand(iss_rs1, wb_valid, wb_rd, wb_data, rf_rd1);
      op_b_d     = sel_operand(iss_rs2, wb_valid, wb_rd, wb_data, rf_rd2);
      op_rd_d    = iss_rd;
      op_rd_en_d = iss_rd_en;
    end else if (op_ready) begin
      op_valid_d = 1'b0;
    end
  end

  // Output register; reset discards any bundle in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_valid_q <= 1'b0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      op_rd_q    <= '0;
      op_rd_en_q <= 1'b0;
    end else begin
      op_valid_q <= op_valid_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      op_rd_q    <= op_rd_d;
      op_rd_en_q <= op_rd_en_d;
    end
  end

  assign op_valid = op_valid_q;
  assign op_a     = op_a_q;
  assign op_b     = op_b_q;
  assign op_rd    = op_rd_q;
  assign op_rd_en = op_rd_en_q;

endmodule

// File: tb/tb_regfile_operand_fetch.sv
// Bench for regfile_operand_fetch: directed table, corner sequences, random traffic vs a model.
module tb_regfile_operand_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        iss_valid, iss_ready, iss_rd_en;
  logic [4:0]  iss_rs1, iss_rs2, iss_rd;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        op_valid, op_ready, op_rd_en;
  logic [31:0] op_a, op_b;
  logic [4:0]  op_rd;
  logic [4:0]  rf_a1, rf_a2, rf_a3;
  logic [31:0] rf_rd1, rf_rd2, rf_wd3;
  logic        rf_we3;
  logic [31:0] busy_mask;
  logic        wb_err;

  always #5 clk = ~clk;

  regfile_operand_fetch dut (
    .clk(clk), .rst(rst),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2),
    .iss_rd(iss_rd), .iss_rd_en(iss_rd_en),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .op_rd(op_rd), .op_rd_en(op_rd_en),
    .rf_a1(rf_a1), .rf_a2(rf_a2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
    .rf_a3(rf_a3), .rf_wd3(rf_wd3), .rf_we3(rf_we3),
    .busy_mask(busy_mask), .wb_err(wb_err)
  );

  // Environment register file driven by the DUT's ports.
  logic [31:0] env_rf [32];
  assign rf_rd1 = env_rf[rf_a1];
  assign rf_rd2 = env_rf[rf_a2];
  always @(posedge clk) if (rf_we3) env_rf[rf_a3] <= rf_wd3;

  // Reference model state.
  logic [31:0] m_rf [32];
  logic [31:0] m_busy;
  logic        m_err, m_opv, m_rd_en;
  logic [31:0] m_a, m_b;
  logic [4:0]  m_rd;
  logic        smp_rdy, smp_we3;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = '0; m_err = 1'b0; m_opv = 1'b0;
    m_a = '0; m_b = '0; m_rd = '0; m_rd_en = 1'b0;
  endtask

  function automatic logic eff_busy(input logic [4:0] r, input logic wv, input logic [4:0] wr);
    return (r != 0) && m_busy[r] && !(wv && wr == r);
  endfunction

  function automatic logic [31:0] operand(input logic [4:0] rs, input logic wv,
                                          input logic [4:0] wr, input logic [31:0] wd);
    if (rs == 0) return 32'h0;
    if (wv && wr == rs) return wd;
    return m_rf[rs];
  endfunction

  // One clock: drive at negedge, check combinational outputs, advance model, check state after edge.
  task automatic cycle(input logic iv, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic rd_en, input logic wv,
                       input logic [4:0] wr, input logic [31:0] wd, input logic ordy);
    logic hz, rdy, acc;
    @(negedge clk);
    iss_valid = iv; iss_rs1 = rs1; iss_rs2 = rs2; iss_rd = rd; iss_rd_en = rd_en;
    wb_valid = wv; wb_rd = wr; wb_data = wd; op_ready = ordy;
    #1;
    hz  = eff_busy(rs1, wv, wr) || eff_busy(rs2, wv, wr) || (rd_en && eff_busy(rd, wv, wr));
    rdy = (!m_opv || ordy) && !hz;
    acc = iv && rdy;
    smp_rdy = iss_ready;
    smp_we3 = rf_we3;
    chk("iss_ready", iss_ready, rdy);
    chk("rf_we3", rf_we3, wv && wr != 0);
    chk("rf_a1", rf_a1, rs1);
    chk("rf_a3_wd3", {rf_a3, rf_wd3[26:0]}, {wr, wd[26:0]});
    if (acc) begin
      m_opv = 1'b1;
      m_a = operand(rs1, wv, wr, wd);
      m_b = operand(rs2, wv, wr, wd);
      m_rd = rd; m_rd_en = rd_en;
    end else if (ordy) begin
      m_opv = 1'b0;
    end
    if (wv && wr != 0 && !m_busy[wr]) m_err = 1'b1;
    if (wv) m_busy[wr] = 1'b0;
    if (acc && rd_en && rd != 0) m_busy[rd] = 1'b1;
    if (wv && wr != 0) m_rf[wr] = wd;
    @(posedge clk);
    #1;
    chk("op_valid", op_valid, m_opv);
    chk("op_a", op_a, m_a);
    chk("op_b", op_b, m_b);
    chk("op_rd", {op_rd_en, op_rd}, {m_rd_en, m_rd});
    chk("busy_mask", busy_mask, m_busy);
    chk("wb_err", wb_err, m_err);
  endtask

  typedef struct {
    logic        iv;
    logic [4:0]  rs1, rs2, rd;
    logic        rd_en, wv;
    logic [4:0]  wr;
    logic [31:0] wd;
    logic        exp_rdy, exp_we3, exp_opv;
    logic [31:0] exp_a, exp_b;
  } vec_t;

  vec_t vecs [6];
  logic [31:0] hold_a, hold_b;

  initial begin
    for (int i = 0; i < 32; i++) begin
      env_rf[i] = 32'h1000_0000 + i * 32'h111;
      m_rf[i]   = env_rf[i];
    end
    env_rf[1] = 32'hA; m_rf[1] = 32'hA;
    env_rf[2] = 32'hB; m_rf[2] = 32'hB;
    env_rf[0] = 32'h0; m_rf[0] = 32'h0;

    iss_valid = 0; iss_rs1 = 0; iss_rs2 = 0; iss_rd = 0; iss_rd_en = 0;
    wb_valid = 0; wb_rd = 0; wb_data = 0; op_ready = 1;
    model_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_op_valid", op_valid, 1'b0);
    chk("rst_op_ab", op_a | op_b, 32'h0);
    chk("rst_op_rd", {op_rd_en, op_rd}, 6'h0);
    chk("rst_busy", busy_mask, 32'h0);
    chk("rst_wb_err", wb_err, 1'b0);
    @(negedge clk);
    rst = 1'b1;

    // Directed table: issue/read, RAW stall then bypass, x0 handling.
    //           iv rs1 rs2 rd en wv wr wd          rdy we3 opv a       b
    vecs[0] = '{1, 1, 2, 3, 1, 0, 0, 32'h0,     1, 0, 1, 32'hA,  32'hB};
    vecs[1] = '{1, 0, 0, 5, 1, 0, 0, 32'h0,     1, 0, 1, 32'h0,  32'h0};
    vecs[2] = '{1, 5, 0, 6, 0, 0, 0, 32'h0,     0, 0, 0, 32'h0,  32'h0};
    vecs[3] = '{1, 5, 0, 6, 0, 1, 5, 32'h55,    1, 1, 1, 32'h55, 32'h0};
    vecs[4] = '{1, 0, 0, 0, 1, 0, 0, 32'h0,     1, 0, 1, 32'h0,  32'h0};
    vecs[5] = '{0, 0, 0, 0, 0, 1, 0, 32'h77,    1, 0, 0, 32'h0,  32'h0};
    for (int i = 0; i < 6; i++) begin
      cycle(vecs[i].iv, vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].rd_en,
            vecs[i].wv, vecs[i].wr, vecs[i].wd, 1'b1);
      chk($sformatf("tbl%0d_rdy", i), smp_rdy, vecs[i].exp_rdy);
      chk($sformatf("tbl%0d_we3", i), smp_we3, vecs[i].exp_we3);
      chk($sformatf("tbl%0d_opv", i), op_valid, vecs[i].exp_opv);
      chk($sformatf("tbl%0d_a", i), op_a, vecs[i].exp_a);
      chk($sformatf("tbl%0d_b", i), op_b, vecs[i].exp_b);
    end
    chk("tbl_busy3", busy_mask[3], 1'b1);
    chk("tbl_busy5", busy_mask[5], 1'b0);
    chk("tbl_busy0", busy_mask[0], 1'b0);
    chk("tbl_err", wb_err, 1'b0);

    // Backpressure: bundle holds for three stalled cycles, then next issue goes straight in.
    cycle(1, 1, 2, 8, 1, 0, 0, 0, 1);
    hold_a = op_a; hold_b = op_b;
    for (int i = 0; i < 3; i++) begin
      cycle(1, 2, 1, 10, 1, 0, 0, 0, 0);
      chk("stall_rdy", smp_rdy, 1'b0);
      chk("stall_hold", {op_a[15:0], op_b[15:0]}, {hold_a[15:0], hold_b[15:0]});
      chk("stall_valid", op_valid, 1'b1);
    end
    cycle(1, 2, 1, 10, 1, 0, 0, 0, 1);
    chk("release_rdy", smp_rdy, 1'b1);
    chk("release_ab", {op_a[15:0], op_b[15:0]}, 32'h000B_000A);

    // Same-register clear and set in one edge: set wins.
    cycle(1, 0, 0, 7, 1, 0, 0, 0, 1);
    cycle(1, 0, 0, 7, 1, 1, 7, 32'h700, 1);
    chk("setwins_rdy", smp_rdy, 1'b1);
    chk("setwins_busy7", busy_mask[7], 1'b1);
    chk("setwins_err", wb_err, 1'b0);

    // Writeback to an idle register: write still happens, error latches.
    cycle(1, 0, 0, 12, 1, 1, 9, 32'h99, 1);
    chk("err_we3", smp_we3, 1'b1);
    chk("err_set", wb_err, 1'b1);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("err_sticky", wb_err, 1'b1);
    chk("err_regwrite", env_rf[9], 32'h99);

    // Asynchronous reset mid-stream clears state without waiting for an edge.
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("arst_busy", busy_mask, 32'h0);
    chk("arst_opv", op_valid, 1'b0);
    chk("arst_err", wb_err, 1'b0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;

    // Random traffic against the model; writebacks mostly target pending registers.
    for (int n = 0; n < 400; n++) begin
      logic [4:0] pend [$];
      logic [4:0] wr;
      for (int r = 1; r < 8; r++) if (m_busy[r]) pend.push_back(r[4:0]);
      if (pend.size() > 0 && $urandom_range(3, 0) != 0)
        wr = pend[$urandom_range(pend.size() - 1, 0)];
      else
        wr = 5'($urandom_range(7, 0));
      cycle(1'($urandom_range(1, 0) | $urandom_range(1, 0)),
            5'($urandom_range(7, 0)), 5'($urandom_range(7, 0)), 5'($urandom_range(7, 0)),
            1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), wr, $urandom,
            1'($urandom_range(3, 0) != 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
